// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port round-robin arbiter sharing a synchronous-read instruction ROM
module rom_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE = '0,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 32'h0001_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_rerr_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_rerr_o,
    output logic              rom_re_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_inst_i
);
    // one extra bit so the upper bound cannot wrap at the top of the address space
    localparam logic [ADDR_W:0] LO = {1'b0, MEM_BASE};
    localparam logic [ADDR_W:0] HI = LO + {1'b0, MEM_SIZE} - (ADDR_W+1)'(4);
    logic              pend_v_q, pend_v_d;
    logic              pend_id_q, pend_id_d;
    logic              pend_err_q, pend_err_d;
    logic              last_gnt_q, last_gnt_d;
    logic              elig0, elig1, err, v0, v1;
    logic [ADDR_W-1:0] gaddr;
    always_comb begin
        elig0       = rst_i & m0_req_i & ~flush_i;
        elig1       = rst_i & m1_req_i;
        m0_gnt_o    = elig0 & (~elig1 | last_gnt_q);
        m1_gnt_o    = elig1 & (~elig0 | ~last_gnt_q);
        gaddr       = m1_gnt_o ? m1_addr_i : m0_addr_i;
        err         = (gaddr[1:0] != 2'b00) | ({1'b0, gaddr} < LO) | ({1'b0, gaddr} > HI);
        rom_re_o    = (m0_gnt_o | m1_gnt_o) & ~err;
        rom_addr_o  = rom_re_o ? gaddr : '0;
        pend_v_d    = m0_gnt_o | m1_gnt_o;
        pend_id_d   = m1_gnt_o;
        pend_err_d  = err;
        last_gnt_d  = m1_gnt_o ? 1'b1 : m0_gnt_o ? 1'b0 : last_gnt_q;
        v0          = pend_v_q & ~pend_id_q & ~flush_i;
        v1          = pend_v_q & pend_id_q;
        m0_rvalid_o = v0;
        m0_rerr_o   = v0 & pend_err_q;
        m0_rdata_o  = (v0 & ~pend_err_q) ? rom_inst_i : '0;
        m1_rvalid_o = v1;
        m1_rerr_o   = v1 & pend_err_q;
        m1_rdata_o  = (v1 & ~pend_err_q) ? rom_inst_i : '0;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_v_q   <= 1'b0;
            pend_id_q  <= 1'b0;
            pend_err_q <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_id_q  <= pend_id_d;
            pend_err_q <= pend_err_d;
            last_gnt_q <= last_gnt_d;
        end
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port round-robin arbiter that shares the single synchronous-read instruction ROM between the fetch stage (port 0) and the load/store unit (port 1). It handles read-only constant loads from the code region. The block sits between the core and the ROM. It drives the ROM read enable and address, then routes the ROM's one-cycle-late word back to the requester that owns it. It also range-checks and alignment-checks every request, and lets a pipeline flush discard an in-flight fetch.

## Interface
- ADDR_W, 32, system address width (`SYS_ADDR_SPACE`)
- DATA_W, 32, instruction/data word width (`INST_WIDTH`)
- MEM_BASE, `MEM_BASE`, first byte address mapped to the ROM
- MEM_SIZE, `MEM_SIZE`, ROM size in bytes
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush; blocks port-0 grant this cycle and kills a port-0 response due this cycle
- m0_req_i / m1_req_i  in  1  read request
- m0_addr_i / m1_addr_i  in  ADDR_W  byte address, held stable while req high and gnt low
- m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle (combinational)
- m0_rvalid_o / m1_rvalid_o  out  1  response valid, one cycle after grant
- m0_rdata_o / m1_rdata_o  out  DATA_W  response word
- m0_rerr_o / m1_rerr_o  out  1  response is an error (qualified by rvalid)
- rom_re_o  out  1  ROM read enable
- rom_addr_o  out  ADDR_W  ROM byte address
- rom_inst_i  in  DATA_W  ROM output word, valid one cycle after rom_re_o

## Operation
- Request/grant: a requester raises req with addr and holds both until it sees gnt. Grant completes the handshake in that same cycle. There is no backpressure on responses, and the requester must take rvalid when it arrives.
- Eligibility: port 0 is eligible when `m0_req_i & ~flush_i`. Port 1 is eligible when `m1_req_i`.
- Arbitration, at most one grant per cycle:
  - If only one port is eligible, that port is granted.
  - If both are eligible, the port not granted most recently wins.
  - Register `last_gnt` updates on every grant. It resets to 1, so port 0 wins the first contention.
- Address check on the granted address:
  - err = addr[1:0] != 0, or addr < MEM_BASE, or addr > MEM_BASE+MEM_SIZE-4.
  - Compute the check at ADDR_W+1 bits so there is no wrap-around at the top of the address space.
- ROM drive:
  - On a grant with no error: rom_re_o=1 and rom_addr_o=addr.
  - On an error grant, or when there is no grant: rom_re_o=0 and rom_addr_o=0.
  - The ROM is never accessed for an erroring request.
- Pending registers, loaded every cycle:
  - pend_v = any grant.
  - pend_id = granted port.
  - pend_err = err.
- Response, in the cycle after a grant, to port pend_id:
  - rvalid=1.
  - rdata = pend_err ? 0 : rom_inst_i.
  - rerr = pend_err.
  - The non-owning port sees rvalid=0, rdata=0, rerr=0.
- Flush: if flush_i=1 in the response cycle and pend_id=0, m0_rvalid_o is forced to 0 and the response is dropped. Port-1 responses are never affected by flush_i.
- Reset, including mid-transaction: the pending response is discarded and no rvalid appears after reset release. last_gnt goes to 1.

## Timing
- Reset values:
  - All gnt, rvalid, rerr, rom_re_o = 0.
  - All rdata and rom_addr_o = 0.
  - pend_v=0, last_gnt=1.
- Grant latency is 0 cycles, combinational from req/flush_i/last_gnt. Response latency is exactly 1 cycle after the grant.
- Throughput is 1 request per cycle, fully pipelined. Back-to-back grants to alternating or the same port are legal.
- Under continuous contention, grants strictly alternate 0,1,0,1...
- Simultaneous events:
  - A grant in cycle N and the response to the cycle N-1 grant are independent and may coincide on the same port.
  - A flush in the cycle where port 0 requests and a port-0 response is due blocks the grant and kills the response. Port 1 may still be granted.
- A response to an error grant also takes exactly 1 cycle, with rvalid=1 and rerr=1.

## Test plan
- Reset: assert rst_i=0 asynchronously mid-transfer, with m0 granted and a response pending. Required: all outputs 0 immediately, and no m0_rvalid_o after release.
- Single fetch: m0 at MEM_BASE+8 with ROM word 0x00500093. Required: m0_gnt_o=1 and rom_addr_o=MEM_BASE+8 in cycle N; m0_rvalid_o=1 with m0_rdata_o=0x00500093 in N+1.
- Contention: both ports request continuously for 6 cycles after reset. Required: grants go 0,1,0,1,0,1, and each response is routed to its owner with the ROM data for its address.
- Errors:
  - m1 at MEM_BASE+2 (misaligned). Required: rom_re_o=0, then m1_rvalid_o=1, m1_rerr_o=1, m1_rdata_o=0.
  - m1 at MEM_BASE+MEM_SIZE and at 0xFFFFFFFC. Required: same error response.
  - m1 at MEM_BASE+MEM_SIZE-4. Required: no error.
- Flush: grant m0 in cycle N, pulse flush_i in N+1 with m0 and m1 both requesting. Required: no m0_rvalid_o in N+1, no m0 grant in N+1, m1 granted in N+1.
- Back-to-back port 0 for 4 cycles over addresses +0, +4, +8, +12. Required: 4 consecutive rvalids carrying the matching words, with no bubbles.
